// File: rtl/mmio_unit.sv
// Memory-mapped I/O unit: UART TX holding register, UART RX FIFO and
// cycle/retired-instruction counters in the 0x8xxx_xxxx window.
module mmio_unit #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        inst_retire,
  output logic [31:0] uart_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [7:0] OFF_STAT = 8'h00;
  localparam logic [7:0] OFF_RXD  = 8'h04;
  localparam logic [7:0] OFF_TXD  = 8'h08;
  localparam logic [7:0] OFF_CYC  = 8'h10;
  localparam logic [7:0] OFF_INS  = 8'h14;
  localparam logic [7:0] OFF_CCLR = 8'h18;

  logic [31:0] r_uart_out;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_cyc, r_ins;
  logic [7:0]  r_mem [RX_DEPTH];
  logic [PW-1:0] r_wp, r_rp;

  logic        w_mmio, w_rd, w_wr;
  logic [7:0]  w_off;
  logic        w_empty, w_full, w_push, w_pop;
  logic        w_tx_load, w_cclr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_mmio   = (addr[31:28] == 4'b1000);
  assign w_off    = addr[7:0];
  assign w_rd     = re & w_mmio;
  assign w_wr     = we & w_mmio;
  assign w_unused = &{1'b0, addr[27:8], wdata[31:8]};

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_empty  = (r_wp == r_rp);
  assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign rx_ready = ~w_full & rst;
  assign w_push   = rx_valid & rx_ready;
  assign w_pop    = w_rd && (w_off == OFF_RXD) && !w_empty;

  // A store to a full holding register is dropped even if it drains this edge.
  assign w_tx_load = w_wr && (w_off == OFF_TXD) && !r_tx_valid;
  assign w_cclr    = w_wr && (w_off == OFF_CCLR);

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_STAT: w_rdata = {30'b0, ~w_empty, ~r_tx_valid};
      OFF_RXD:  w_rdata = w_empty ? 32'h0 : {24'b0, r_mem[r_rp[AW-1:0]]};
      OFF_CYC:  w_rdata = r_cyc;
      OFF_INS:  w_rdata = r_ins;
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_uart_out <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_cyc      <= '0;
      r_ins      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      if (w_rd) r_uart_out <= w_rdata;

      if (w_tx_load) begin
        r_tx_data  <= wdata[7:0];
        r_tx_valid <= 1'b1;
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      if (w_cclr) begin
        r_cyc <= '0;
        r_ins <= '0;
      end else begin
        r_cyc <= r_cyc + 32'd1;
        r_ins <= r_ins + {31'b0, inst_retire};
      end

      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= rx_data;
  end

  assign uart_out = r_uart_out;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
endmodule

// File: tb/tb_mmio_unit.sv
// Directed bench for mmio_unit: counters, TX handshake, RX FIFO and decode.
module tb_mmio_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        re, we, inst_retire;
  logic [31:0] uart_out;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  int n_tot = 0;
  int n_bad = 0;

  mmio_unit #(.RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wdata(wdata),
    .inst_retire(inst_retire), .uart_out(uart_out), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    re = 1'b1; addr = a;
    cyc();
    re = 1'b0; addr = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    cyc();
    rx_valid = 1'b0; rx_data = '0;
  endtask

  logic [7:0] exp_rx [5];

  initial begin
    rst = 1'b0; addr = '0; wdata = '0; re = 1'b0; we = 1'b0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // Reset and counters
    repeat (3) cyc();
    chk("rst_uart_out", uart_out, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data",  {24'b0, tx_data}, 32'h0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      inst_retire = (i <= 5);
      if (i == 10) begin re = 1'b1; addr = 32'h8000_0010; end
      cyc();
    end
    re = 1'b0; addr = '0; inst_retire = 1'b0;
    chk("cyc_at_10", uart_out, 32'd9);
    chk("rx_ready_out_of_rst", {31'b0, rx_ready}, 32'h1);
    rd(32'h8000_0014);
    chk("ins_cnt", uart_out, 32'd5);
    wr(32'h8000_0018, 32'h1234);
    rd(32'h8000_0010);
    chk("cyc_after_clr", uart_out, 32'd0);
    rd(32'h8000_0014);
    chk("ins_after_clr", uart_out, 32'd0);

    // TX handshake
    rd(32'h8000_0000);
    chk("stat_tx_idle", uart_out, 32'h1);
    wr(32'h8000_0008, 32'h41);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin we = 1'b1; addr = 32'h8000_0008; wdata = 32'h42; end
      if (i == 2) begin re = 1'b1; addr = 32'h8000_0000; end
      cyc();
      we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
      chk("tx_stall_valid", {31'b0, tx_valid}, 32'h1);
      chk("tx_stall_data",  {24'b0, tx_data}, 32'h41);
      if (i == 2) chk("stat_tx_busy", uart_out, 32'h0);
    end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("tx_done_valid", {31'b0, tx_valid}, 32'h0);
    chk("tx_done_data",  {24'b0, tx_data}, 32'h41);
    rd(32'h8000_0000);
    chk("stat_tx_free", uart_out, 32'h1);

    // RX FIFO fill and drain
    push(8'h11); push(8'h22); push(8'h33);
    chk("rx_ready_3", {31'b0, rx_ready}, 32'h1);
    push(8'h44);
    chk("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    push(8'h55);
    rd(32'h8000_0000);
    chk("stat_rx_full", uart_out, 32'h3);
    exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h33; exp_rx[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      rd(32'h8000_0004);
      chk("rx_pop", uart_out, {24'b0, exp_rx[i]});
      if (i == 0) chk("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
    end
    rd(32'h8000_0000);
    chk("stat_rx_empty", uart_out, 32'h1);
    rd(32'h8000_0004);
    chk("rx_pop_empty", uart_out, 32'h0);

    // Simultaneous push and pop
    push(8'hA0);
    re = 1'b1; addr = 32'h8000_0004; rx_valid = 1'b1; rx_data = 8'hB0;
    cyc();
    re = 1'b0; addr = '0; rx_valid = 1'b0; rx_data = '0;
    chk("pushpop_rd", uart_out, 32'hA0);
    rd(32'h8000_0004);
    chk("pushpop_next", uart_out, 32'hB0);
    rd(32'h8000_0000);
    chk("pushpop_empty", uart_out, 32'h1);

    // Empty FIFO: read and push together, read returns 0, push lands
    re = 1'b1; addr = 32'h8000_0004; rx_valid = 1'b1; rx_data = 8'hC0;
    cyc();
    re = 1'b0; addr = '0; rx_valid = 1'b0; rx_data = '0;
    chk("empty_rd_push", uart_out, 32'h0);

    // Decode isolation
    rd(32'h1000_0004);
    chk("nonmmio_hold", uart_out, 32'h0);
    rd(32'h8000_0004);
    chk("nonmmio_nopop", uart_out, 32'hC0);
    rd(32'h1000_0004);
    chk("nonmmio_hold2", uart_out, 32'hC0);
    rd(32'h8000_0020);
    chk("unmapped_rd", uart_out, 32'h0);
    wr(32'h1000_0008, 32'h77);
    chk("nonmmio_tx", {31'b0, tx_valid}, 32'h0);

    // Reset mid-operation drops TX byte and FIFO contents
    wr(32'h8000_0008, 32'h5A);
    push(8'hD0);
    rst = 1'b0; tx_ready = 1'b1;
    cyc();
    rst = 1'b1; tx_ready = 1'b0;
    chk("rst_mid_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_mid_tx_data",  {24'b0, tx_data}, 32'h0);
    chk("rst_mid_uart_out", uart_out, 32'h0);
    rd(32'h8000_0000);
    chk("rst_mid_stat", uart_out, 32'h1);
    rd(32'h8000_0010);
    chk("rst_mid_cyc", uart_out, 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
